// File: rtl/mac_vert_col_sched_pkg.sv
// Shared types and constants for the vertical bit-column MAC column sequencer.
package mac_vert_pkg;

  localparam int CMD_MASK_W     = 8;
  localparam int MAC_PIPE_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CMD_MASK_W-1:0] mask;
    logic                  first;
    logic                  last;
    logic [2:0]            mul_const;
    logic                  is_shift_mul;
  } cmd_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/mac_vert_col_sched_if.sv
// Tile command handshake plus the MAC control bundle driven by the column sequencer.
interface mac_vert_col_sched_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int COL_IDX_WIDTH = $clog2(DATA_WIDTH)
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [DATA_WIDTH-1:0]    cmd_col_mask;
  logic                     cmd_first;
  logic                     cmd_last;
  logic [2:0]               cmd_mul_const;
  logic                     cmd_is_shift_mul;

  logic                     mac_en;
  logic                     load_accum;
  logic [COL_IDX_WIDTH-1:0] column_idx;
  logic                     is_msb;
  logic [2:0]               mul_const;
  logic                     is_shift_mul;
  logic                     col_vld;
  logic                     result_valid;
  logic                     busy;

  modport master (
    output cmd_valid, cmd_col_mask, cmd_first, cmd_last, cmd_mul_const, cmd_is_shift_mul,
    input  cmd_ready, mac_en, load_accum, column_idx, is_msb, mul_const, is_shift_mul,
           col_vld, result_valid, busy
  );

  modport slave (
    input  cmd_valid, cmd_col_mask, cmd_first, cmd_last, cmd_mul_const, cmd_is_shift_mul,
    output cmd_ready, mac_en, load_accum, column_idx, is_msb, mul_const, is_shift_mul,
           col_vld, result_valid, busy
  );
endinterface

// File: rtl/mac_vert_col_sched_col_lsb_finder.sv
// Combinational lowest-set-bit encoder; last_one flags that only one bit remains.
module col_lsb_finder #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          found,
  output logic          last_one
);

  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

  assign found    = |mask;
  assign last_one = found && ((mask & (mask - W'(1))) == '0);

endmodule

// File: rtl/mac_vert_col_sched.sv
// Column sequencer for the vertical bit-column MAC: walks set columns LSB->MSB per tile.
// Optional perf counters are enabled with `define MAC_VERT_SCHED_PERF_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a tile command, MAC frozen
// ISSUE | one column (or one bubble for an empty mask) per cycle
// DRAIN | MAC_PIPE_DEPTH zero-term cycles to flush the MAC pipe
// DONE  | result_valid pulse, MAC frozen
module mac_vert_col_sched #(
  parameter int DATA_WIDTH     = mac_vert_pkg::CMD_MASK_W,
  parameter int COL_IDX_WIDTH  = $clog2(DATA_WIDTH),
  parameter int MAC_PIPE_DEPTH = mac_vert_pkg::MAC_PIPE_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  mac_vert_col_sched_if.slave  bus
`ifdef MAC_VERT_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_skipped,
  output logic [31:0]          perf_bubbles
`endif
);
  import mac_vert_pkg::*;

  localparam int CNT_W = (MAC_PIPE_DEPTH > 1) ? $clog2(MAC_PIPE_DEPTH) : 1;

  state_t             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic               first_issue_q, first_issue_d;
  logic               load_q, load_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [COL_IDX_WIDTH-1:0] lsb_idx;
  logic               lsb_found, lsb_last;
  logic               last_col;
  logic               accept;
  logic               load_set;
  logic               mac_en_c, col_vld_c, issue_real;

  col_lsb_finder #(
    .W  (DATA_WIDTH),
    .IW (COL_IDX_WIDTH)
  ) u_lsb (
    .mask     (cmd_q.mask),
    .idx      (lsb_idx),
    .found    (lsb_found),
    .last_one (lsb_last)
  );

  // An empty mask still counts as a (bubble) last column.
  assign last_col   = !lsb_found || lsb_last;
  assign issue_real = (state_q == ISSUE) && lsb_found;

  always_comb begin
    state_d          = state_q;
    cmd_d            = cmd_q;
    first_issue_d    = first_issue_q;
    cnt_d            = cnt_q;
    accept           = 1'b0;
    load_set         = 1'b0;
    mac_en_c         = 1'b0;
    col_vld_c        = 1'b0;
    bus.cmd_ready    = 1'b0;
    bus.column_idx   = '0;
    bus.is_msb       = 1'b0;
    bus.mul_const    = 3'd0;
    bus.is_shift_mul = 1'b0;
    bus.result_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mac_en_c      = 1'b1;
        col_vld_c     = lsb_found;
        first_issue_d = 1'b0;
        if (lsb_found) begin
          bus.column_idx = lsb_idx;
          bus.is_msb     = (lsb_idx == COL_IDX_WIDTH'(DATA_WIDTH - 1));
          cmd_d.mask     = cmd_q.mask & ~({{(DATA_WIDTH-1){1'b0}}, 1'b1} << lsb_idx);
        end
        if (first_issue_q) begin
          bus.mul_const    = cmd_q.mul_const;
          bus.is_shift_mul = cmd_q.is_shift_mul;
          load_set         = cmd_q.first;
        end
        if (last_col) begin
          if (cmd_q.last) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(MAC_PIPE_DEPTH - 1);
          end else begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) accept = 1'b1;
            else               state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        mac_en_c = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        bus.result_valid = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      cmd_d.mask         = bus.cmd_col_mask;
      cmd_d.first        = bus.cmd_first;
      cmd_d.last         = bus.cmd_last;
      cmd_d.mul_const    = bus.cmd_mul_const;
      cmd_d.is_shift_mul = bus.cmd_is_shift_mul;
      first_issue_d      = 1'b1;
    end

    // load_accum waits out any frozen (mac_en=0) gap so it meets the next enabled MAC cycle.
    load_d = load_set || (load_q && !mac_en_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      first_issue_q <= 1'b0;
      load_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      first_issue_q <= first_issue_d;
      load_q        <= load_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.mac_en     = mac_en_c;
  assign bus.col_vld    = col_vld_c;
  assign bus.load_accum = load_q;
  assign bus.busy       = (state_q != IDLE);

`ifdef MAC_VERT_SCHED_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_skipped_q, perf_skipped_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_issued_d  = perf_issued_q;
    perf_skipped_d = perf_skipped_q;
    perf_bubbles_d = perf_bubbles_q;
    if (issue_real)
      perf_issued_d = sat_add32(perf_issued_q, 32'd1);
    if (accept)
      perf_skipped_d = sat_add32(perf_skipped_q,
                                 32'(DATA_WIDTH) - 32'($countones(bus.cmd_col_mask)));
    if (mac_en_c && !col_vld_c)
      perf_bubbles_d = sat_add32(perf_bubbles_q, 32'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issued_q  <= '0;
      perf_skipped_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_issued_q  <= perf_issued_d;
      perf_skipped_q <= perf_skipped_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_issued  = perf_issued_q;
  assign perf_skipped = perf_skipped_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  logic unused_issue;
  assign unused_issue = issue_real;
`endif

endmodule

// File: tb/tb_mac_vert_col_sched.sv
// Directed bench for mac_vert_col_sched; outputs are sampled 1ns after each rising edge.
module tb_mac_vert_col_sched;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mac_vert_col_sched_if #(.DATA_WIDTH(8), .COL_IDX_WIDTH(3)) bus_if ();

`ifdef MAC_VERT_SCHED_PERF_CNT_EN
  logic [31:0] perf_issued, perf_skipped, perf_bubbles;
`endif

  mac_vert_col_sched #(
    .DATA_WIDTH     (8),
    .COL_IDX_WIDTH  (3),
    .MAC_PIPE_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
`ifdef MAC_VERT_SCHED_PERF_CNT_EN
    ,
    .perf_issued  (perf_issued),
    .perf_skipped (perf_skipped),
    .perf_bubbles (perf_bubbles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mac_en, col_vld, is_msb, load_accum, result_valid, cmd_ready, busy, column_idx, mul_const, is_shift_mul}
  logic [13:0] obs;
  assign obs = {bus_if.mac_en, bus_if.col_vld, bus_if.is_msb, bus_if.load_accum,
                bus_if.result_valid, bus_if.cmd_ready, bus_if.busy,
                bus_if.column_idx, bus_if.mul_const, bus_if.is_shift_mul};

  function automatic logic [13:0] ev(input logic me, input logic cv, input logic msb,
                                     input logic ld, input logic rv, input logic rdy,
                                     input logic bsy, input logic [2:0] idx,
                                     input logic [2:0] mc, input logic sh);
    return {me, cv, msb, ld, rv, rdy, bsy, idx, mc, sh};
  endfunction

  localparam logic [13:0] IDLE_V = 14'b00000_1_0_000_000_0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic [7:0] m, input logic f,
                           input logic l, input logic [2:0] mc, input logic sh);
    bus_if.cmd_valid        = v;
    bus_if.cmd_col_mask     = m;
    bus_if.cmd_first        = f;
    bus_if.cmd_last         = l;
    bus_if.cmd_mul_const    = mc;
    bus_if.cmd_is_shift_mul = sh;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_cmd(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    #3;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_async: got %h want %h", obs, IDLE_V);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_held: got %h want %h", obs, IDLE_V);
    end
    reset = 1'b1;
    next_cycle();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", obs, IDLE_V);
    end
  endtask

  task automatic test_single_tile();
    logic [13:0] exp_a [7];
    exp_a[0] = ev(1,1,0,0,0,0,1,3'd0,3'd3,0);
    exp_a[1] = ev(1,1,0,1,0,0,1,3'd2,3'd0,0);
    exp_a[2] = ev(1,1,1,0,0,0,1,3'd7,3'd0,0);
    exp_a[3] = ev(1,0,0,0,0,0,1,3'd0,3'd0,0);
    exp_a[4] = ev(1,0,0,0,0,0,1,3'd0,3'd0,0);
    exp_a[5] = ev(0,0,0,0,1,0,1,3'd0,3'd0,0);
    exp_a[6] = IDLE_V;
    drive_cmd(1'b1, 8'b1000_0101, 1'b1, 1'b1, 3'd3, 1'b0);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL single_accept: got %h want %h", obs, IDLE_V);
    end
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      bus_if.cmd_valid = 1'b0;
      checks++;
      if (obs !== exp_a[k]) begin
        errors++;
        $display("FAIL single_tile cyc %0d: got %h want %h", k + 1, obs, exp_a[k]);
      end
    end
  endtask

`ifdef MAC_VERT_SCHED_PERF_CNT_EN
  task automatic test_perf_cnt();
    checks++;
    if (perf_issued !== 32'd3) begin
      errors++;
      $display("FAIL perf_issued: got %0d want 3", perf_issued);
    end
    checks++;
    if (perf_skipped !== 32'd5) begin
      errors++;
      $display("FAIL perf_skipped: got %0d want 5", perf_skipped);
    end
    checks++;
    if (perf_bubbles !== 32'd2) begin
      errors++;
      $display("FAIL perf_bubbles: got %0d want 2", perf_bubbles);
    end
  endtask
`endif

  task automatic test_empty_mask();
    logic [13:0] exp_a [5];
    exp_a[0] = ev(1,0,0,0,0,0,1,3'd0,3'd5,1);
    exp_a[1] = ev(1,0,0,1,0,0,1,3'd0,3'd0,0);
    exp_a[2] = ev(1,0,0,0,0,0,1,3'd0,3'd0,0);
    exp_a[3] = ev(0,0,0,0,1,0,1,3'd0,3'd0,0);
    exp_a[4] = IDLE_V;
    drive_cmd(1'b1, 8'h00, 1'b1, 1'b1, 3'd5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      bus_if.cmd_valid = 1'b0;
      checks++;
      if (obs !== exp_a[k]) begin
        errors++;
        $display("FAIL empty_mask cyc %0d: got %h want %h", k + 1, obs, exp_a[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp_a [7];
    int rv_cnt;
    rv_cnt = 0;
    exp_a[0] = ev(1,1,0,0,0,0,1,3'd0,3'd2,0);
    exp_a[1] = ev(1,1,0,1,0,1,1,3'd1,3'd0,0);
    exp_a[2] = ev(1,1,1,0,0,0,1,3'd7,3'd4,0);
    exp_a[3] = ev(1,0,0,0,0,0,1,3'd0,3'd0,0);
    exp_a[4] = ev(1,0,0,0,0,0,1,3'd0,3'd0,0);
    exp_a[5] = ev(0,0,0,0,1,0,1,3'd0,3'd0,0);
    exp_a[6] = IDLE_V;
    drive_cmd(1'b1, 8'h03, 1'b1, 1'b0, 3'd2, 1'b0);
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      if (k == 0) drive_cmd(1'b1, 8'h80, 1'b0, 1'b1, 3'd4, 1'b0);
      if (k == 2) bus_if.cmd_valid = 1'b0;
      if (bus_if.result_valid === 1'b1) rv_cnt++;
      checks++;
      if (obs !== exp_a[k]) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", k + 1, obs, exp_a[k]);
      end
    end
    next_cycle();
    if (bus_if.result_valid === 1'b1) rv_cnt++;
    checks++;
    if (rv_cnt != 1) begin
      errors++;
      $display("FAIL back_to_back_rv_count: got %0d want 1", rv_cnt);
    end
  endtask

  task automatic test_full_mask();
    logic [13:0] e;
    drive_cmd(1'b1, 8'hFF, 1'b1, 1'b0, 3'd1, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      bus_if.cmd_valid = 1'b0;
      if (k == 9) e = IDLE_V;
      else e = ev(1'b1, 1'b1, k == 8, k == 2, 1'b0, k == 8, 1'b1,
                  3'(k - 1), (k == 1) ? 3'd1 : 3'd0, k == 1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL full_mask cyc %0d: got %h want %h", k, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    logic [13:0] e1, e2;
    e1 = ev(1,1,0,0,0,0,1,3'd0,3'd3,0);
    e2 = ev(1,1,0,1,0,0,1,3'd2,3'd0,0);
    drive_cmd(1'b1, 8'b1000_0101, 1'b1, 1'b1, 3'd3, 1'b0);
    next_cycle();
    bus_if.cmd_valid = 1'b0;
    checks++;
    if (obs !== e1) begin
      errors++;
      $display("FAIL midrst_idx0: got %h want %h", obs, e1);
    end
    next_cycle();
    checks++;
    if (obs !== e2) begin
      errors++;
      $display("FAIL midrst_idx2: got %h want %h", obs, e2);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL midrst_abort: got %h want %h", obs, IDLE_V);
    end
    next_cycle();
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      checks++;
      if (obs !== IDLE_V) begin
        errors++;
        $display("FAIL midrst_after cyc %0d: got %h want %h", k, obs, IDLE_V);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_tile();
`ifdef MAC_VERT_SCHED_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_empty_mask();
    test_back_to_back();
    test_full_mask();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
